// File: rtl/draw_pkg.sv
`default_nettype none
// ============================================================================
//  Module     : draw_pkg
//  Description: Shared definitions for the stroke renderer: FSM state
//               encoding, default cursor/background colours and the brush
//               size clamp helper.
//  Revision   : 1.0 - initial release
// ============================================================================
package draw_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_CLEAR      = 3'd1,
        ST_CURS_ERASE = 3'd2,
        ST_LINE_STEP  = 3'd3,
        ST_STAMP      = 3'd4,
        ST_CURS_DRAW  = 3'd5
    } state_t;

    localparam logic [8:0] DEF_CURSOR_COLOR = 9'b111000000;
    localparam logic [8:0] DEF_BG_COLOR     = 9'b000000000;

    // A zero brush still paints one pixel; oversize requests saturate.
    function automatic logic [3:0] clamp_brush(input logic [3:0] size,
                                               input logic [3:0] max_size);
        if (size == 4'd0)
            return 4'd1;
        else if (size > max_size)
            return max_size;
        else
            return size;
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_stepper.sv
`default_nettype none
// ============================================================================
//  Module     : line_stepper
//  Description: Bresenham line walker. A start pulse loads both endpoints and
//               presents the first point; each step_en advances one point
//               until the end point is reached (done).
//  Ports      : clk, rst_n          - clock, async active-low reset
//               start, step_en      - load endpoints / advance one point
//               x0,y0,x1,y1         - start and end coordinates
//               cur_x,cur_y,done    - current point, end point reached
//  Revision   : 1.0 - initial release
// ============================================================================
module line_stepper #(
    parameter int X_BITS = 9,
    parameter int Y_BITS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              step_en,
    input  logic [X_BITS-1:0] x0,
    input  logic [Y_BITS-1:0] y0,
    input  logic [X_BITS-1:0] x1,
    input  logic [Y_BITS-1:0] y1,
    output logic [X_BITS-1:0] cur_x,
    output logic [Y_BITS-1:0] cur_y,
    output logic              done
);

    localparam int E = X_BITS + 2;
    localparam logic signed [E-1:0] ZERO_S = '0;
    localparam logic [X_BITS-1:0]   ONE_X  = X_BITS'(1);
    localparam logic [Y_BITS-1:0]   ONE_Y  = Y_BITS'(1);

    logic [X_BITS-1:0]   end_x;
    logic [Y_BITS-1:0]   end_y;
    logic signed [E-1:0] err;
    logic signed [E-1:0] dx;      // |x1-x0|
    logic signed [E-1:0] dy;      // -|y1-y0|
    logic                sx_neg;
    logic                sy_neg;

    logic signed [E-1:0] ddx, ddy, abs_dx, abs_dy, err_next;
    logic signed [E:0]   e2, dx_w, dy_w;
    logic                take_x, take_y;

    always_comb begin
        ddx      = $signed(E'(x1)) - $signed(E'(x0));
        ddy      = $signed(E'(y1)) - $signed(E'(y0));
        abs_dx   = ddx[E-1] ? -ddx : ddx;
        abs_dy   = ddy[E-1] ? -ddy : ddy;
        e2       = $signed({err, 1'b0});
        dx_w     = $signed({dx[E-1], dx});
        dy_w     = $signed({dy[E-1], dy});
        take_x   = (e2 >= dy_w);
        take_y   = (e2 <= dx_w);
        err_next = err + (take_x ? dy : ZERO_S) + (take_y ? dx : ZERO_S);
    end

    assign done = (cur_x == end_x) && (cur_y == end_y);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_x  <= '0;
            cur_y  <= '0;
            end_x  <= '0;
            end_y  <= '0;
            err    <= '0;
            dx     <= '0;
            dy     <= '0;
            sx_neg <= 1'b0;
            sy_neg <= 1'b0;
        end else if (start) begin
            cur_x  <= x0;
            cur_y  <= y0;
            end_x  <= x1;
            end_y  <= y1;
            dx     <= abs_dx;
            dy     <= -abs_dy;
            err    <= abs_dx - abs_dy;
            sx_neg <= ddx[E-1];
            sy_neg <= ddy[E-1];
        end else if (step_en && !done) begin
            err <= err_next;
            if (take_x)
                cur_x <= sx_neg ? cur_x - ONE_X : cur_x + ONE_X;
            if (take_y)
                cur_y <= sy_neg ? cur_y - ONE_Y : cur_y + ONE_Y;
        end
    end

endmodule
`default_nettype wire

// File: rtl/stroke_render_engine.sv
`default_nettype none
// ============================================================================
//  Module     : stroke_render_engine
//  Description: Turns accepted cursor positions and pen state into a stream
//               of single-pixel framebuffer writes: cross cursor draw/erase,
//               full-screen clear, Bresenham-filled strokes with a square
//               brush, all clipped per pixel to the visible screen.
//  Ports      : CLOCK_50, resetn                 - clock, async active-low reset
//               pos_valid/pos_x/pos_y/pos_ready  - position handshake
//               btn_draw, btn_erase, brush_size,
//               ink_color                        - pen state, sampled on transfer
//               clear_req                        - full-screen clear request
//               pix_x/pix_y/pix_color/pix_write  - registered write port
//               busy                             - engine not idle
//  Revision   : 1.0 - initial release
// ============================================================================
module stroke_render_engine
    import draw_pkg::*;
#(
    parameter int                    SCREEN_W     = 320,
    parameter int                    SCREEN_H     = 240,
    parameter int                    X_BITS       = 9,
    parameter int                    Y_BITS       = 8,
    parameter int                    COLOR_BITS   = 9,
    parameter int                    BRUSH_MAX    = 8,
    parameter int                    CURSOR_ARM   = 10,
    parameter logic [COLOR_BITS-1:0] CURSOR_COLOR = DEF_CURSOR_COLOR,
    parameter logic [COLOR_BITS-1:0] BG_COLOR     = DEF_BG_COLOR
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic                  pos_valid,
    input  logic [X_BITS-1:0]     pos_x,
    input  logic [Y_BITS-1:0]     pos_y,
    output logic                  pos_ready,
    input  logic                  btn_draw,
    input  logic                  btn_erase,
    input  logic [3:0]            brush_size,
    input  logic [COLOR_BITS-1:0] ink_color,
    input  logic                  clear_req,
    output logic [X_BITS-1:0]     pix_x,
    output logic [Y_BITS-1:0]     pix_y,
    output logic [COLOR_BITS-1:0] pix_color,
    output logic                  pix_write,
    output logic                  busy
);

    localparam int E           = X_BITS + 2;
    localparam int ARM_SPAN    = 2 * CURSOR_ARM + 1;
    localparam int CURS_CYCLES = 2 * ARM_SPAN;
    localparam int CW          = $clog2(CURS_CYCLES);

    localparam logic [CW-1:0]       SPAN_C    = CW'(ARM_SPAN);
    localparam logic [CW-1:0]       CURS_LAST = CW'(CURS_CYCLES - 1);
    localparam logic signed [E-1:0] ARM_S     = E'(CURSOR_ARM);
    localparam logic signed [E-1:0] SW_S      = E'(SCREEN_W);
    localparam logic signed [E-1:0] SH_S      = E'(SCREEN_H);
    localparam logic signed [E-1:0] ZERO_S    = '0;
    localparam logic [X_BITS-1:0]   CX0       = X_BITS'(SCREEN_W / 2);
    localparam logic [Y_BITS-1:0]   CY0       = Y_BITS'(SCREEN_H / 2);
    localparam logic [X_BITS-1:0]   X_MAX     = X_BITS'(SCREEN_W - 1);
    localparam logic [Y_BITS-1:0]   Y_MAX     = Y_BITS'(SCREEN_H - 1);
    localparam logic [X_BITS:0]     SW_EXT    = (X_BITS+1)'(SCREEN_W);
    localparam logic [Y_BITS:0]     SH_EXT    = (Y_BITS+1)'(SCREEN_H);
    localparam logic [3:0]          BMAX4     = 4'(BRUSH_MAX);

    state_t                  state;
    logic                    cursor_visible;
    logic                    pen_down;        // pen state of the previous transfer
    logic [X_BITS-1:0]       last_x, new_x;
    logic [Y_BITS-1:0]       last_y, new_y;
    logic                    new_pen, new_draw;
    logic [3:0]              brush;
    logic [COLOR_BITS-1:0]   ink;
    logic [CW-1:0]           curs_cnt;
    logic [X_BITS-1:0]       clr_x;
    logic [Y_BITS-1:0]       clr_y;
    logic [3:0]              stamp_i, stamp_j;
    logic                    line_start, line_step;

    logic [X_BITS-1:0]       line_x;
    logic [Y_BITS-1:0]       line_y;
    logic                    line_done;

    assign pos_ready = (state == ST_IDLE) && !clear_req;
    assign busy      = (state != ST_IDLE);

    // A stroke continues from the last point only when the pen was already
    // down; otherwise the "line" degenerates to the new point alone.
    line_stepper #(
        .X_BITS (X_BITS),
        .Y_BITS (Y_BITS)
    ) u_line_stepper (
        .clk     (CLOCK_50),
        .rst_n   (resetn),
        .start   (line_start),
        .step_en (line_step),
        .x0      (pen_down ? last_x : new_x),
        .y0      (pen_down ? last_y : new_y),
        .x1      (new_x),
        .y1      (new_y),
        .cur_x   (line_x),
        .cur_y   (line_y),
        .done    (line_done)
    );

    // Cross cursor pixel: first half of the count sweeps the row, second half
    // the column; coordinates are signed so off-screen arms can be clipped.
    logic                curs_horiz;
    logic [CW-1:0]       arm_idx;
    logic signed [E-1:0] arm_off, curs_xs, curs_ys;
    logic                curs_in;

    always_comb begin
        curs_horiz = (curs_cnt < SPAN_C);
        arm_idx    = curs_horiz ? curs_cnt : curs_cnt - SPAN_C;
        arm_off    = $signed(E'(arm_idx)) - ARM_S;
        curs_xs    = $signed(E'(last_x)) + (curs_horiz ? arm_off : ZERO_S);
        curs_ys    = $signed(E'(last_y)) + (curs_horiz ? ZERO_S : arm_off);
        curs_in    = !curs_xs[E-1] && (curs_xs < SW_S) &&
                     !curs_ys[E-1] && (curs_ys < SH_S);
    end

    // Brush pixel, one bit wider than the screen coordinate to catch overflow.
    logic [X_BITS:0] stamp_x;
    logic [Y_BITS:0] stamp_y;
    logic            stamp_in;

    always_comb begin
        stamp_x  = {1'b0, line_x} + (X_BITS+1)'(stamp_i);
        stamp_y  = {1'b0, line_y} + (Y_BITS+1)'(stamp_j);
        stamp_in = (stamp_x < SW_EXT) && (stamp_y < SH_EXT);
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state          <= ST_CURS_DRAW;
            cursor_visible <= 1'b0;
            pen_down       <= 1'b0;
            last_x         <= CX0;
            last_y         <= CY0;
            new_x          <= CX0;
            new_y          <= CY0;
            new_pen        <= 1'b0;
            new_draw       <= 1'b0;
            brush          <= 4'd1;
            ink            <= '0;
            curs_cnt       <= '0;
            clr_x          <= '0;
            clr_y          <= '0;
            stamp_i        <= '0;
            stamp_j        <= '0;
            line_start     <= 1'b0;
            line_step      <= 1'b0;
            pix_x          <= '0;
            pix_y          <= '0;
            pix_color      <= '0;
            pix_write      <= 1'b0;
        end else begin
            pix_write  <= 1'b0;
            line_start <= 1'b0;
            line_step  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clear_req) begin
                        state <= ST_CLEAR;
                        clr_x <= '0;
                        clr_y <= '0;
                    end else if (pos_valid) begin
                        new_x    <= pos_x;
                        new_y    <= pos_y;
                        new_pen  <= btn_draw | btn_erase;
                        new_draw <= btn_draw;
                        brush    <= clamp_brush(brush_size, BMAX4);
                        ink      <= ink_color;
                        curs_cnt <= '0;
                        if (cursor_visible) begin
                            // Pen-up onto the same spot: cursor already there.
                            if (!(btn_draw | btn_erase) && pos_x == last_x && pos_y == last_y)
                                pen_down <= 1'b0;
                            else
                                state <= ST_CURS_ERASE;
                        end else if (btn_draw | btn_erase) begin
                            state      <= ST_LINE_STEP;
                            line_start <= 1'b1;
                        end else begin
                            state    <= ST_CURS_DRAW;
                            last_x   <= pos_x;
                            last_y   <= pos_y;
                            pen_down <= 1'b0;
                        end
                    end
                end

                ST_CLEAR: begin
                    pix_x     <= clr_x;
                    pix_y     <= clr_y;
                    pix_color <= BG_COLOR;
                    pix_write <= 1'b1;
                    if (clr_x == X_MAX) begin
                        clr_x <= '0;
                        if (clr_y == Y_MAX) begin
                            cursor_visible <= 1'b0;
                            curs_cnt       <= '0;
                            state          <= ST_CURS_DRAW;
                        end else begin
                            clr_y <= clr_y + Y_BITS'(1);
                        end
                    end else begin
                        clr_x <= clr_x + X_BITS'(1);
                    end
                end

                ST_CURS_ERASE, ST_CURS_DRAW: begin
                    pix_x     <= curs_xs[X_BITS-1:0];
                    pix_y     <= curs_ys[Y_BITS-1:0];
                    pix_color <= (state == ST_CURS_DRAW) ? CURSOR_COLOR : BG_COLOR;
                    pix_write <= curs_in;
                    curs_cnt  <= curs_cnt + CW'(1);
                    if (curs_cnt == CURS_LAST) begin
                        curs_cnt <= '0;
                        if (state == ST_CURS_DRAW) begin
                            cursor_visible <= 1'b1;
                            state          <= ST_IDLE;
                        end else begin
                            cursor_visible <= 1'b0;
                            if (new_pen) begin
                                state      <= ST_LINE_STEP;
                                line_start <= 1'b1;
                            end else begin
                                state    <= ST_CURS_DRAW;
                                last_x   <= new_x;
                                last_y   <= new_y;
                                pen_down <= 1'b0;
                            end
                        end
                    end
                end

                // One cycle for the stepper to load/advance, then stamp.
                ST_LINE_STEP: begin
                    if (!(line_start || line_step)) begin
                        state   <= ST_STAMP;
                        stamp_i <= '0;
                        stamp_j <= '0;
                    end
                end

                ST_STAMP: begin
                    pix_x     <= stamp_x[X_BITS-1:0];
                    pix_y     <= stamp_y[Y_BITS-1:0];
                    pix_color <= new_draw ? ink : BG_COLOR;
                    pix_write <= stamp_in;
                    if (stamp_i == brush - 4'd1) begin
                        stamp_i <= '0;
                        if (stamp_j == brush - 4'd1) begin
                            stamp_j <= '0;
                            if (line_done) begin
                                state    <= ST_IDLE;
                                last_x   <= new_x;
                                last_y   <= new_y;
                                pen_down <= 1'b1;
                            end else begin
                                state     <= ST_LINE_STEP;
                                line_step <= 1'b1;
                            end
                        end else begin
                            stamp_j <= stamp_j + 4'd1;
                        end
                    end else begin
                        stamp_i <= stamp_i + 4'd1;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stroke_render_engine.sv
`default_nettype none
// ============================================================================
//  Module     : tb_stroke_render_engine
//  Description: Directed self-checking bench for stroke_render_engine.
//               Captures every write strobe and compares counts, colours and
//               coordinates against hand-computed values.
//  Revision   : 1.0 - initial release
// ============================================================================
module tb_stroke_render_engine;

    localparam logic [8:0] CUR = 9'b111000000;
    localparam logic [8:0] BG  = 9'b000000000;

    logic       clk = 1'b0;
    logic       resetn;
    logic       pos_valid;
    logic [8:0] pos_x;
    logic [7:0] pos_y;
    logic       pos_ready;
    logic       btn_draw, btn_erase;
    logic [3:0] brush_size;
    logic [8:0] ink_color;
    logic       clear_req;
    logic [8:0] pix_x;
    logic [7:0] pix_y;
    logic [8:0] pix_color;
    logic       pix_write;
    logic       busy;

    stroke_render_engine dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .pos_valid  (pos_valid),
        .pos_x      (pos_x),
        .pos_y      (pos_y),
        .pos_ready  (pos_ready),
        .btn_draw   (btn_draw),
        .btn_erase  (btn_erase),
        .brush_size (brush_size),
        .ink_color  (ink_color),
        .clear_req  (clear_req),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_color  (pix_color),
        .pix_write  (pix_write),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [8:0] c;
    } pix_t;

    pix_t q[$];
    int   vectors    = 0;
    int   miscompares = 0;

    // Strobes are sampled 1 time unit after the rising edge.
    always @(posedge clk) begin
        #1;
        if (pix_write === 1'b1)
            q.push_back({pix_x, pix_y, pix_color});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_xy(input string tag, input int idx, input logic [8:0] ex, input logic [7:0] ey);
        logic [31:0] obs;
        obs = (idx < q.size()) ? 32'({q[idx].x, q[idx].y}) : 32'hFFFF_FFFF;
        chk(tag, obs, 32'({ex, ey}));
    endtask

    function automatic int count_color(input logic [8:0] c);
        int n = 0;
        foreach (q[i]) if (q[i].c == c) n++;
        return n;
    endfunction

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 32'(busy), 32'd0);
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (pos_ready !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic xfer(input logic [8:0] x, input logic [7:0] y, input logic d, input logic e,
                        input logic [3:0] b, input logic [8:0] ink);
        wait_ready(1000);
        q.delete();
        pos_x = x; pos_y = y; btn_draw = d; btn_erase = e;
        brush_size = b; ink_color = ink; pos_valid = 1'b1;
        @(negedge clk);
        pos_valid = 1'b0;
        wait_idle(2000);
    endtask

    initial begin
        int n;
        int minx;
        resetn = 1'b0; pos_valid = 1'b0; pos_x = '0; pos_y = '0;
        btn_draw = 1'b0; btn_erase = 1'b0; brush_size = 4'd1;
        ink_color = '0; clear_req = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_pix_write", 32'(pix_write), 32'd0);
        chk("rst_pos_ready", 32'(pos_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        q.delete();
        resetn = 1'b1;
        wait_idle(200);
        chk("init_count", q.size(), 42);
        chk("init_cursor_color", count_color(CUR), 42);
        chk_xy("init_first", 0, 9'd150, 8'd120);
        chk_xy("init_h_end", 20, 9'd170, 8'd120);
        chk_xy("init_v_start", 21, 9'd160, 8'd110);
        chk_xy("init_last", 41, 9'd160, 8'd130);
        chk("init_ready", 32'(pos_ready), 32'd1);

        // Pen-up to the top-right corner: erase 42, draw 11+11 clipped cross
        xfer(9'd319, 8'd0, 1'b0, 1'b0, 4'd1, 9'd0);
        chk("corner_count", q.size(), 64);
        chk("corner_bg", count_color(BG), 42);
        chk("corner_cur", count_color(CUR), 22);
        minx = 999;
        foreach (q[i]) if (q[i].c == CUR && int'(q[i].x) < minx) minx = int'(q[i].x);
        chk("corner_no_wrap", 32'(minx), 32'd309);
        chk_xy("corner_erase_first", 0, 9'd150, 8'd120);
        chk_xy("corner_draw_first", 42, 9'd309, 8'd0);
        chk_xy("corner_draw_last", 63, 9'd319, 8'd10);

        xfer(9'd100, 8'd100, 1'b0, 1'b0, 4'd1, 9'd0);
        chk("move_count", q.size(), 64);

        // Two draw transfers: single stamp, then a Bresenham segment
        xfer(9'd10, 8'd10, 1'b1, 1'b0, 4'd1, 9'h0AB);
        chk("dot_count", q.size(), 43);
        chk_xy("dot_xy", 42, 9'd10, 8'd10);
        chk("dot_color", count_color(9'h0AB), 1);
        xfer(9'd14, 8'd12, 1'b1, 1'b0, 4'd1, 9'h0AB);
        chk("line_count", q.size(), 5);
        chk("line_color", count_color(9'h0AB), 5);
        chk_xy("line_p0", 0, 9'd10, 8'd10);
        chk_xy("line_p1", 1, 9'd11, 8'd11);
        chk_xy("line_p2", 2, 9'd12, 8'd11);
        chk_xy("line_p3", 3, 9'd13, 8'd12);
        chk_xy("line_p4", 4, 9'd14, 8'd12);

        // Brush clipping near the bottom-right corner
        xfer(9'd318, 8'd238, 1'b0, 1'b0, 4'd1, 9'd0);
        chk("br_cursor_count", q.size(), 24);
        xfer(9'd318, 8'd238, 1'b1, 1'b0, 4'd0, 9'h155);
        chk("br0_count", q.size(), 25);
        chk("br0_ink", count_color(9'h155), 1);
        chk_xy("br0_xy", 24, 9'd318, 8'd238);
        xfer(9'd318, 8'd238, 1'b1, 1'b0, 4'd15, 9'h155);
        chk("br15_count", q.size(), 4);
        chk("br15_ink", count_color(9'h155), 4);
        chk_xy("br15_p1", 1, 9'd319, 8'd238);
        chk_xy("br15_p3", 3, 9'd319, 8'd239);

        // Pen-up after pen-down redraws the cursor; a repeat does nothing
        xfer(9'd318, 8'd238, 1'b0, 1'b0, 4'd1, 9'd0);
        chk("penup_redraw", q.size(), 24);
        xfer(9'd318, 8'd238, 1'b0, 1'b0, 4'd1, 9'd0);
        chk("penup_nop", q.size(), 0);

        // Clear beats a simultaneous position
        q.delete();
        pos_x = 9'd200; pos_y = 8'd50; btn_draw = 1'b0; btn_erase = 1'b0;
        clear_req = 1'b1; pos_valid = 1'b1;
        #1;
        chk("clr_pos_ready", 32'(pos_ready), 32'd0);
        @(negedge clk);
        clear_req = 1'b0;
        chk("clr_busy", 32'(busy), 32'd1);
        wait_ready(80000);
        chk("clr_ready", 32'(pos_ready), 32'd1);
        chk("clr_count", q.size(), 76824);
        chk("clr_bg", count_color(BG), 76800);
        chk("clr_cursor", count_color(CUR), 24);
        chk_xy("clr_first", 0, 9'd0, 8'd0);
        chk_xy("clr_row1", 320, 9'd0, 8'd1);
        chk_xy("clr_last", 76799, 9'd319, 8'd239);
        @(negedge clk);
        pos_valid = 1'b0;
        wait_idle(2000);
        chk("clr_then_accept", q.size(), 76890);

        // Reset asserted while stamping
        wait_ready(1000);
        q.delete();
        pos_x = 9'd50; pos_y = 8'd50; btn_draw = 1'b1; btn_erase = 1'b0;
        brush_size = 4'd8; ink_color = 9'h0F0; pos_valid = 1'b1;
        @(negedge clk);
        pos_valid = 1'b0;
        n = 0;
        while (!(q.size() > 0 && q[q.size()-1].c == 9'h0F0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("stamp_reached", 32'(pix_write), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_pix_write", 32'(pix_write), 32'd0);
        chk("async_ready", 32'(pos_ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        q.delete();
        resetn = 1'b1;
        wait_idle(200);
        chk("restart_count", q.size(), 42);
        chk("restart_cursor", count_color(CUR), 42);
        chk_xy("restart_first", 0, 9'd150, 8'd120);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
